// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
// The processor-side master port imports the same package.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    // Little-endian byte-lane enables for a legal size/offset pair.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << offs;
            HSIZE_HALF: m = offs[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic size_error(input logic [2:0] size, input logic [1:0] offs);
        return (size > HSIZE_WORD)
            || ((size == HSIZE_HALF) && offs[0])
            || ((size == HSIZE_WORD) && (offs != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM: byte-enabled synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ahb_sram_mem #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic [3:0]            i_be,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting an on-chip SRAM with programmable wait states
// and a two-cycle ERROR response for misaligned or illegal-size transfers.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW = ADDR_WIDTH + 2;
    localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slave_state_t  r_state, w_state_nxt;
    logic [2:0]    r_wait_cnt, w_wait_cnt_nxt;
    logic          r_pend, w_pend_nxt;
    logic [AW-1:0] r_addr;
    logic          r_write;
    logic [2:0]    r_size;

    logic          w_accept;
    logic          w_cap;
    logic          w_err;
    logic          w_done;
    logic          w_rd_phase;
    logic [3:0]    w_be;
    logic [31:0]   w_mem_rdata;
    logic          w_unused;

    assign w_unused = ^{HBURST, HADDR[31:AW], HTRANS[0]};

    // A new address phase is only taken when this slave is not stalling the bus.
    assign w_accept = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign w_cap    = w_accept && HSEL && HREADY && HTRANS[1];
    assign w_err    = size_error(HSIZE, HADDR[1:0]);

    // r_pend in IDLE marks the completing cycle of an OKAY data phase.
    assign w_done     = r_pend && (r_state == ST_IDLE);
    assign w_rd_phase = r_pend && !r_write
                     && ((r_state == ST_IDLE) || (r_state == ST_WAIT));
    assign w_be       = (w_done && r_write && HRESETn) ? lane_mask(r_size, r_addr[1:0]) : '0;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_pend     <= 1'b0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_size     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_pend     <= w_pend_nxt;
            if (w_cap) begin
                r_addr  <= HADDR[AW-1:0];
                r_write <= HWRITE;
                r_size  <= HSIZE;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_pend_nxt     = r_pend;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_state_nxt    = ST_IDLE;
                w_wait_cnt_nxt = '0;
                w_pend_nxt     = 1'b0;
                if (w_cap) begin
                    if (w_err) begin
                        w_state_nxt = ST_ERR1;
                    end else begin
                        w_pend_nxt = 1'b1;
                        if (WAIT_STATES > 0) begin
                            w_state_nxt    = ST_WAIT;
                            w_wait_cnt_nxt = WS_M1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 3'd1;
                end
            end
            ST_ERR1: begin
                w_state_nxt = ST_ERR2;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign HREADYOUT = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
    assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = w_rd_phase ? w_mem_rdata : '0;

    ahb_sram_mem #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .i_clk   (HCLK),
        .i_be    (w_be),
        .i_addr  (r_addr[AW-1:2]),
        .i_wdata (HWDATA),
        .o_rdata (w_mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances with 0, 3 and 2
// wait states share one master; only the active instance is selected.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int NDUT = 3;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        r_hsel;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    int          act;

    logic        w_ready [NDUT];
    logic [1:0]  w_resp  [NDUT];
    logic [31:0] w_rdata [NDUT];

    always #5 HCLK = ~HCLK;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic w_sel;
        assign w_sel = r_hsel && (act == g);
        ahb_sram_slave #(
            .ADDR_WIDTH  (10),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .HSEL      (w_sel),
            .HADDR     (HADDR),
            .HTRANS    (HTRANS),
            .HWRITE    (HWRITE),
            .HSIZE     (HSIZE),
            .HBURST    (HBURST),
            .HWDATA    (HWDATA),
            .HREADY    (w_ready[g]),
            .HREADYOUT (w_ready[g]),
            .HRESP     (w_resp[g]),
            .HRDATA    (w_rdata[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    typedef struct {
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } item_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          waits;
    } exp_t;

    item_t      q_items[$];
    exp_t       q_exp[$];
    bit [31:0]  m_mem[int];

    task automatic add(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        item_t it;
        it.trans = tr;
        it.wr    = wr;
        it.size  = sz;
        it.addr  = a;
        it.wdata = d;
        q_items.push_back(it);
    endtask

    // Reference behaviour: predicts the data-phase outcome and updates the memory model.
    function automatic exp_t model(input int k, input item_t it);
        exp_t        e;
        int          key;
        logic [31:0] w;
        bit          err;
        e.rdata = '0;
        e.resp  = 2'b00;
        e.waits = 0;
        if (!it.trans[1]) return e;
        err = (it.size > 3'd2) || (it.size == 3'd1 && it.addr[0])
           || (it.size == 3'd2 && it.addr[1:0] != 2'b00);
        if (err) begin
            e.resp  = 2'b01;
            e.waits = 1;
            return e;
        end
        e.waits = ws_of(k);
        key = k * 65536 + int'(it.addr[11:2]);
        w = m_mem.exists(key) ? m_mem[key] : 32'h0;
        if (it.wr) begin
            for (int b = 0; b < 4; b++) begin
                bit sel;
                case (it.size)
                    3'd0:    sel = (b == int'(it.addr[1:0]));
                    3'd1:    sel = ((b / 2) == int'(it.addr[1]));
                    default: sel = 1'b1;
                endcase
                if (sel) w[8*b +: 8] = it.wdata[8*b +: 8];
            end
            m_mem[key] = w;
        end else begin
            e.rdata = w;
        end
        return e;
    endfunction

    task automatic drive_idle();
        r_hsel = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HSIZE  = HSIZE_WORD;
        HADDR  = '0;
    endtask

    // Pipelined master: next address phase overlaps the completing data phase.
    task automatic run(input int k);
        item_t ap, dp;
        bit    have_ap = 0;
        bit    have_dp = 0;
        int    waits = 0;
        int    cyc = 0;
        exp_t  e;
        act = k;
        while ((q_items.size() > 0 || have_ap || have_dp) && cyc < 500) begin
            if (have_ap) begin
                dp = ap;
                have_dp = 1;
                have_ap = 0;
                waits = 0;
                HWDATA = dp.wdata;
            end
            if (have_dp) begin
                if (w_ready[k]) begin
                    e = q_exp.pop_front();
                    check($sformatf("resp[%0d]@%h", k, dp.addr), 32'(w_resp[k]), 32'(e.resp));
                    check($sformatf("rdata[%0d]@%h", k, dp.addr), w_rdata[k], e.rdata);
                    check($sformatf("waits[%0d]@%h", k, dp.addr), 32'(waits), 32'(e.waits));
                    have_dp = 0;
                end else begin
                    waits++;
                    check($sformatf("wait_resp[%0d]@%h", k, dp.addr), 32'(w_resp[k]), 32'(q_exp[0].resp));
                end
            end
            if (!have_dp && q_items.size() > 0) begin
                ap = q_items.pop_front();
                q_exp.push_back(model(k, ap));
                r_hsel = 1'b1;
                HTRANS = ap.trans;
                HWRITE = ap.wr;
                HSIZE  = ap.size;
                HADDR  = ap.addr;
                have_ap = 1;
            end else begin
                drive_idle();
            end
            @(posedge HCLK);
            #1;
            cyc++;
        end
        check($sformatf("run_drained[%0d]", k), {31'b0, have_dp | have_ap}, 32'd0);
        q_items.delete();
        q_exp.delete();
    endtask

    initial begin
        HRESETn = 1'b0;
        HBURST  = 3'b000;
        HWDATA  = '0;
        act     = 0;
        drive_idle();
        repeat (2) @(posedge HCLK);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_ready[%0d]", k), 32'(w_ready[k]), 32'd1);
            check($sformatf("rst_resp[%0d]", k), 32'(w_resp[k]), 32'd0);
            check($sformatf("rst_rdata[%0d]", k), w_rdata[k], 32'd0);
        end
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Zero-wait instance: word, byte/halfword, errors, IDLE/BUSY, aliasing, top word.
        add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
        add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h21, 32'h0000AA00);
        add(HTRANS_SEQ,    1'b1, HSIZE_HALF, 32'h22, 32'h12340000);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
        add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h13, 32'hFFFFFFFF);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        add(HTRANS_NONSEQ, 1'b1, 3'b011,     32'h10, 32'h0BADF00D);
        add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h10, 32'h0);
        add(HTRANS_BUSY,   1'b0, HSIZE_WORD, 32'h10, 32'h0);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        add(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h21, 32'h00FFFF00);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_BYTE, 32'h23, 32'h0);
        add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_1020, 32'h5A5AA5A5);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
        add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hFFC, 32'h01020304);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'hFFC, 32'h0);
        run(0);

        // Three wait states.
        add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'hCAFEF00D);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h42, 32'h0);
        add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h43, 32'h77000000);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
        run(1);

        // Two wait states, then reset during the write's WAIT phase.
        add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'h11111111);
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30, 32'h0);
        run(2);

        act    = 2;
        r_hsel = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = 1'b1;
        HSIZE  = HSIZE_WORD;
        HADDR  = 32'h30;
        @(posedge HCLK);
        #1;
        drive_idle();
        HWDATA = 32'h55555555;
        check("rst_mid_inwait", 32'(w_ready[2]), 32'd0);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        check("rst_mid_ready", 32'(w_ready[2]), 32'd1);
        check("rst_mid_resp", 32'(w_resp[2]), 32'd0);
        check("rst_mid_rdata", w_rdata[2], 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30, 32'h0);
        run(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
